sipo_capture_sfr: RTL

SIPO_CAPTURE_SFR -- requirements
Module: sipo_capture_sfr

---
 rtl/sipo_capture_sfr.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sipo_capture_sfr.sv
// sipo_capture_sfr: serial-in / parallel-out capture register with a holding register.
//
// Bits are shifted into an internal shift register on each shift_en. When SIZE bits have
// been taken, the assembled word is copied into the holding register Q and valid is raised.
// The shift register keeps capturing while Q waits for the consumer to pulse rd.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   clr        synchronous clear of all state, highest priority
//   shift_en   sample sdi on this edge
//   sdi        serial data in
//   msb_first  1: left shift, sdi enters bit 0; 0: right shift, sdi enters bit SIZE-1
//   rd         consumer acknowledge of Q, ignored while valid = 0
//   Q          last completed word
//   valid      Q holds an unread word
//   overrun    sticky flag, a completed word was lost
//   bit_cnt    bits captured so far in the current word
//
// Configuration macro SIPO_OVERRUN_PROTECT_EN:
//   defined   - a word completing while Q is unread is dropped and overrun is set
//   undefined - such a word overwrites Q, valid stays 1 and overrun is tied to 0

module sipo_capture_sfr #(
  parameter int unsigned SIZE = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     shift_en,
  input  logic                     sdi,
  input  logic                     msb_first,
  input  logic                     rd,
  output logic [SIZE-1:0]          Q,
  output logic                     valid,
  output logic                     overrun,
  output logic [$clog2(SIZE)-1:0]  bit_cnt
);

  localparam int unsigned CW = $clog2(SIZE);
  localparam logic [CW-1:0] CntMax = CW'(SIZE - 1);

`ifdef SIPO_OVERRUN_PROTECT_EN
  localparam bit Protect = 1'b1;
`else
  localparam bit Protect = 1'b0;
`endif

  logic [SIZE-1:0] sr_q, sr_d;
  logic [SIZE-1:0] q_q, q_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic            complete;
  logic            load;
  logic            ack;

  assign complete = shift_en && (cnt_q == CntMax);
  assign ack      = rd && valid_q;
  // A completed word reaches Q unless an unread word is being protected.
  assign load     = complete && (!valid_q || rd || !Protect);

  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    valid_d = valid_q;

    if (shift_en) begin
      if (msb_first) begin
        sr_d = {sr_q[SIZE-2:0], sdi};
      end else begin
        sr_d = {sdi, sr_q[SIZE-1:1]};
      end
      cnt_d = complete ? '0 : cnt_q + 1'b1;
    end

    if (load) begin
      // Post-shift value so the bit sampled on this edge is part of the word.
      q_d     = sr_d;
      valid_d = 1'b1;
    end else if (ack && !complete) begin
      valid_d = 1'b0;
    end

    if (clr) begin
      sr_d    = '0;
      cnt_d   = '0;
      q_d     = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      valid_q <= valid_d;
    end
  end

`ifdef SIPO_OVERRUN_PROTECT_EN
  logic ovr_q, ovr_d;

  always_comb begin
    ovr_d = ovr_q;
    if (clr) begin
      ovr_d = 1'b0;
    end else if (complete && valid_q && !rd) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign overrun = ovr_q;
`else
  assign overrun = 1'b0;
`endif

  assign Q       = q_q;
  assign valid   = valid_q;
  assign bit_cnt = cnt_q;

endmodule
